// File: rtl/uart_rxd.sv
// 8N1 UART receiver with self-timed bit sampling; emits one-cycle done/error pulses per frame.
// Bits are sampled mid-bit by counting I_clk cycles from the synchronized start edge.
module uart_rxd #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_rs232_rxd,
    output logic [7:0] O_para_data,
    output logic       O_rx_done,
    output logic       O_frame_err,
    output logic       O_rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = $clog2(BIT_CNT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             rxd_meta_r;
    logic             rxd_sync_r;
    logic             rxd_dly_r;
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       sh_r, sh_s;
    logic [7:0]       data_r, data_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             busy_r, busy_s;
    logic             start_edge_s;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; line idles high.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_dly_r  <= 1'b1;
        end else begin
            rxd_meta_r <= I_rs232_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_dly_r  <= rxd_sync_r;
        end
    end

    assign start_edge_s = rxd_dly_r & ~rxd_sync_r;

    // Next-state and datapath decisions for the frame FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        sh_s    = sh_r;
        data_s  = data_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        busy_s  = busy_r;
        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (start_edge_s) begin
                    state_s = START;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    // A line back high at mid start bit was a glitch, not a frame.
                    if (!rxd_sync_r) begin
                        state_s = DATA;
                        idx_s   = 3'd0;
                    end else begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s       = CNT_ZERO;
                    sh_s[idx_r] = rxd_sync_r;
                    if (idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    // Return at mid stop bit so an immediately following start edge is caught.
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    if (rxd_sync_r) begin
                        data_s = sh_r;
                        done_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            sh_r    <= 8'h00;
            data_r  <= 8'h00;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            sh_r    <= sh_s;
            data_r  <= data_s;
            done_r  <= done_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
        end
    end

    assign O_para_data = data_r;
    assign O_rx_done   = done_r;
    assign O_frame_err = err_r;
    assign O_rx_busy   = busy_r;

endmodule
